// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared FIFO definitions: default geometry, pointer width helper and the
// read-mode encodings used by the FIFO controller.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  // Read presentation mode: registered read or first-word-fall-through
  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } read_mode_e;

  // Pointers carry one extra wrap bit above the storage address
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for the single-clock FIFO.
// master = the block driving requests, slave = the FIFO itself.
interface sync_fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  clear;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, wr_en, wdata, rd_en,
    input  rdata, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, wdata, rd_en,
    output rdata, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ctrl_ram.sv
// FIFO storage: 1 write / 1 read register array with a clocked write port
// and an asynchronous read port. Contents are deliberately not reset.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Store the incoming word on an accepted write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, registered status flags,
// sticky error bits, synchronous flush, and standard or FWFT read output.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_ctrl_if.slave bus
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t ONE        = ptr_t'(1);
  localparam ptr_t AF_COUNT   = ptr_t'(AF_LEVEL);
  localparam ptr_t AE_COUNT   = ptr_t'(AE_LEVEL);
  localparam logic AF_AT_ZERO = (AF_LEVEL == 0);
  localparam bit   FWFT_MODE  = (FWFT == int'(MODE_FWFT));

  ptr_t wptr, rptr, count_q;
  ptr_t wptr_next, rptr_next, count_next;
  logic full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic full_next, empty_next;
  logic wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Accept decisions use the flags registered at the start of the cycle
  assign wr_accept = bus.wr_en & ~full_q  & ~bus.clear;
  assign rd_accept = bus.rd_en & ~empty_q & ~bus.clear;

  // Next pointer/occupancy; flush returns everything to the empty state
  always_comb begin
    wptr_next  = wptr;
    rptr_next  = rptr;
    count_next = count_q;
    if (bus.clear) begin
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
    end else begin
      if (wr_accept) wptr_next = wptr + ONE;
      if (rd_accept) rptr_next = rptr + ONE;
      case ({wr_accept, rd_accept})
        2'b10:   count_next = count_q + ONE;
        2'b01:   count_next = count_q - ONE;
        default: count_next = count_q;
      endcase
    end
    empty_next = (wptr_next == rptr_next);
    full_next  = (wptr_next[PW-1] != rptr_next[PW-1]) &&
                 (wptr_next[PW-2:0] == rptr_next[PW-2:0]);
  end

  // Pointer, count and status flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= AF_AT_ZERO;
      ae_q    <= 1'b1;
    end else begin
      wptr    <= wptr_next;
      rptr    <= rptr_next;
      count_q <= count_next;
      full_q  <= full_next;
      empty_q <= empty_next;
      af_q    <= (count_next >= AF_COUNT);
      ae_q    <= (count_next <= AE_COUNT);
    end
  end

  // Sticky error bits: set by a rejected access, cleared only by reset/flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.clear) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (bus.wr_en & full_q);
      udf_q <= udf_q | (bus.rd_en & empty_q);
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (bus.wdata),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT_MODE) begin : g_fwft
      assign bus.rdata    = ram_rdata;
      assign bus.rd_valid = ~empty_q;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;
      logic                  rd_valid_q;

      // Registered read: capture the head word on a pop, valid for one cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q    <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_accept;
          if (rd_accept) rdata_q <= ram_rdata;
        end
      end

      assign bus.rdata    = rdata_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: one standard-read instance and one
// FWFT instance sharing clock and reset.
module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) std_if ();
  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) fw_if ();

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)
  ) dut_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (std_if.slave)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)
  ) dut_fw (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fw_if.slave)
  );

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on the standard instance, return at the following negedge
  task automatic applyStimulus(input logic c, input logic w, input logic [7:0] d,
                               input logic r);
    std_if.clear = c;
    std_if.wr_en = w;
    std_if.wdata = d;
    std_if.rd_en = r;
    @(posedge clk);
    @(negedge clk);
    std_if.clear = 1'b0;
    std_if.wr_en = 1'b0;
    std_if.rd_en = 1'b0;
  endtask

  // Same for the FWFT instance
  task automatic applyFwft(input logic w, input logic [7:0] d, input logic r);
    fw_if.wr_en = w;
    fw_if.wdata = d;
    fw_if.rd_en = r;
    @(posedge clk);
    @(negedge clk);
    fw_if.wr_en = 1'b0;
    fw_if.rd_en = 1'b0;
  endtask

  // Directed sequence
  initial begin
    std_if.clear = 1'b0; std_if.wr_en = 1'b0; std_if.wdata = '0; std_if.rd_en = 1'b0;
    fw_if.clear  = 1'b0; fw_if.wr_en  = 1'b0; fw_if.wdata  = '0; fw_if.rd_en  = 1'b0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_empty", std_if.empty, 1);
    checkOutput("rst_full", std_if.full, 0);
    checkOutput("rst_count", std_if.count, 0);
    checkOutput("rst_ae", std_if.almost_empty, 1);
    checkOutput("rst_af", std_if.almost_full, 0);
    checkOutput("rst_rd_valid", std_if.rd_valid, 0);
    checkOutput("rst_rdata", std_if.rdata, 0);
    checkOutput("rst_ovf", std_if.overflow, 0);
    checkOutput("rst_udf", std_if.underflow, 0);
    checkOutput("rst_fw_valid", fw_if.rd_valid, 0);

    // Reset in the middle of a burst
    applyStimulus(0, 1, 8'h01, 0);
    applyStimulus(0, 1, 8'h02, 0);
    applyStimulus(0, 1, 8'h03, 0);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("burst_rd_valid", std_if.rd_valid, 1);
    checkOutput("burst_rdata", std_if.rdata, 8'h01);
    checkOutput("burst_count", std_if.count, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_empty", std_if.empty, 1);
    checkOutput("async_rst_count", std_if.count, 0);
    checkOutput("async_rst_rd_valid", std_if.rd_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, almost_full from 6, full at 8
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 8'(8'h10 + i), 0);
      checkOutput($sformatf("fill_count_%0d", i), std_if.count, i + 1);
      checkOutput($sformatf("fill_af_%0d", i), std_if.almost_full, (i + 1 >= 6) ? 1 : 0);
      checkOutput($sformatf("fill_full_%0d", i), std_if.full, (i == 7) ? 1 : 0);
    end

    // Write while full is dropped and flagged
    applyStimulus(0, 1, 8'h99, 0);
    checkOutput("ovf_flag", std_if.overflow, 1);
    checkOutput("ovf_count", std_if.count, 8);
    checkOutput("ovf_full", std_if.full, 1);

    // Drain in order, one cycle latency
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 8'h00, 1);
      checkOutput($sformatf("drain_valid_%0d", i), std_if.rd_valid, 1);
      checkOutput($sformatf("drain_rdata_%0d", i), std_if.rdata, 8'h10 + i);
      checkOutput($sformatf("drain_count_%0d", i), std_if.count, 7 - i);
      checkOutput($sformatf("drain_ae_%0d", i), std_if.almost_empty, (7 - i <= 1) ? 1 : 0);
    end
    checkOutput("drain_empty", std_if.empty, 1);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("idle_rd_valid", std_if.rd_valid, 0);
    checkOutput("idle_rdata_hold", std_if.rdata, 8'h17);
    checkOutput("ovf_sticky", std_if.overflow, 1);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("clear_ovf", std_if.overflow, 0);
    checkOutput("clear_count", std_if.count, 0);

    // Read while empty
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("udf_flag", std_if.underflow, 1);
    checkOutput("udf_rd_valid", std_if.rd_valid, 0);
    checkOutput("udf_count", std_if.count, 0);
    applyStimulus(0, 1, 8'h55, 0);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("udf_ptr_rdata", std_if.rdata, 8'h55);
    checkOutput("udf_ptr_empty", std_if.empty, 1);
    checkOutput("udf_sticky", std_if.underflow, 1);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("clear_udf", std_if.underflow, 0);

    // Empty with write+read: write taken, read rejected
    applyStimulus(0, 1, 8'h66, 1);
    checkOutput("empty_wr_rd_count", std_if.count, 1);
    checkOutput("empty_wr_rd_udf", std_if.underflow, 1);
    checkOutput("empty_wr_rd_valid", std_if.rd_valid, 0);
    applyStimulus(1, 0, 8'h00, 0);

    // Steady state at count 4 across pointer wrap
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'(8'h20 + i), 0);
    checkOutput("sim_start_count", std_if.count, 4);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 8'(8'h24 + i), 1);
      checkOutput($sformatf("sim_count_%0d", i), std_if.count, 4);
      checkOutput($sformatf("sim_rdata_%0d", i), std_if.rdata, 8'h20 + i);
    end

    // Full with write+read: read taken, write rejected
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'(8'h40 + i), 0);
    checkOutput("full_before", std_if.full, 1);
    applyStimulus(0, 1, 8'hEE, 1);
    checkOutput("full_wr_rd_count", std_if.count, 7);
    checkOutput("full_wr_rd_ovf", std_if.overflow, 1);
    checkOutput("full_wr_rd_rdata", std_if.rdata, 8'h34);
    checkOutput("full_wr_rd_full", std_if.full, 0);

    // Flush wins over simultaneous requests and raises no errors
    applyStimulus(1, 1, 8'h77, 1);
    checkOutput("clr_rw_count", std_if.count, 0);
    checkOutput("clr_rw_empty", std_if.empty, 1);
    checkOutput("clr_rw_ovf", std_if.overflow, 0);
    checkOutput("clr_rw_udf", std_if.underflow, 0);
    checkOutput("clr_rw_valid", std_if.rd_valid, 0);
    checkOutput("clr_rw_ae", std_if.almost_empty, 1);

    // First-word-fall-through instance
    checkOutput("fw_idle_valid", fw_if.rd_valid, 0);
    applyFwft(1, 8'hA5, 0);
    checkOutput("fw_valid", fw_if.rd_valid, 1);
    checkOutput("fw_rdata", fw_if.rdata, 8'hA5);
    applyFwft(0, 8'h00, 0);
    checkOutput("fw_hold_rdata", fw_if.rdata, 8'hA5);
    applyFwft(0, 8'h00, 1);
    checkOutput("fw_pop_empty", fw_if.empty, 1);
    checkOutput("fw_pop_valid", fw_if.rd_valid, 0);
    applyFwft(1, 8'hC3, 0);
    applyFwft(1, 8'hD4, 0);
    checkOutput("fw_head_c3", fw_if.rdata, 8'hC3);
    applyFwft(0, 8'h00, 1);
    checkOutput("fw_head_d4", fw_if.rdata, 8'hD4);
    checkOutput("fw_d4_valid", fw_if.rd_valid, 1);
    checkOutput("fw_d4_count", fw_if.count, 1);
    applyFwft(0, 8'h00, 1);
    checkOutput("fw_final_empty", fw_if.empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
